player_arb: RTL and testbench
=============================

Name: player_arb

Overview:
Arbiter/sequencer that shares the single tune player (one-hot start, volume, tran_end) between N_REQ requesters such as alarm, hourly chime and key beep. It latches requests and grants by fixed priority, with index 0 the highest. It drives the player's start pulse and volume, and watches tran_end for completion. It also handles preemption, repeat-until-cancel playback with an inter-repeat gap, a watchdog timeout and muting.

Parameters:
N_REQ, 3, number of requesters; index 0 highest priority
MSC_N, 4, number of tunes (width of player start vector)
TW, 2, tune id width; must satisfy 2**TW >= MSC_N
REPEAT_MASK, 3'b001, bit i set means requester i replays until cancelled
GAP_CYC, 1000, idle cycles between repeats (>=1)
TMO_CYC, 32'd50_000_000, watchdog: max cycles in PLAY without tran_end

Ports:
sysclk  in  1  system clock
rst  in  1  synchronous reset, active-high
req  in  N_REQ  per-requester single-cycle request pulse
cancel  in  N_REQ  per-requester single-cycle cancel pulse
req_tune  in  N_REQ*TW  packed tune id, sampled with req[i]
req_vol  in  N_REQ*10  packed volume, sampled with req[i]
mute  in  1  level; forces volume_in to 0
start  out  MSC_N  one-hot, one-cycle tune start to player
volume_in  out  10  volume to player
tran_end  in  1  player pulse: tune finished
grant  out  N_REQ  one-hot, level; the requester currently owning the player
done  out  N_REQ  one-cycle pulse; normal completion
abort  out  N_REQ  one-cycle pulse; preempted, cancelled, timed out or bad tune id
busy  out  1  state != IDLE

Behaviour:
- Synchronous, active-high reset to sysclk. Reset clears all outputs, pending[] and the latched tune/vol registers to 0, and puts the FSM in IDLE. Reset mid-play drops start and grant immediately and produces no done or abort pulse.
- Request latching: req[i] sets pending[i] and latches tune_i/vol_i. A later req[i] overwrites the latched tune/vol.
- cancel[i] clears pending[i]. If req[i] and cancel[i] occur in the same cycle, cancel wins.
- FSM states: IDLE, START, PLAY, GAP.
- IDLE: if any pending bit is set, pick the lowest index j. Copy tune_j/vol_j to act_tune/act_vol, clear pending[j], set act=j, then go to START.
- START (exactly one cycle):
  - start = onehot(act_tune) and grant[act]=1; next state PLAY.
  - If act_tune >= MSC_N: start stays 0, abort[act] pulses next cycle, and the FSM returns to IDLE.
  - tran_end is ignored in START.
- PLAY: the watchdog counter increments each cycle. Exits:
  - tran_end with act in REPEAT_MASK: go to GAP.
  - tran_end otherwise: done[act] pulses next cycle, then IDLE.
  - Counter reaches TMO_CYC-1 without tran_end: abort[act], then IDLE.
- GAP: count GAP_CYC cycles, then START with the same act_tune. grant stays high throughout GAP.
- Preemption, checked in PLAY and GAP: if pending[j] with j < act, then abort[act] pulses and the FSM goes straight to START for j (pending[j] cleared). Lower or equal priority requesters wait. A new req from the active requester sets pending and plays after the current tune ends.
- cancel[act] in START, PLAY or GAP: abort[act], then IDLE. It takes precedence over a same-cycle tran_end or timeout. Preemption takes precedence over cancel of the active requester; the result is one abort pulse.
- volume_in = mute ? 0 : act_vol. It is registered, so it updates one cycle after mute changes, and it holds its value in IDLE.
- Latency: req high in cycle 0 from IDLE → start and grant high in cycle 2. tran_end high in cycle n → done high in cycle n+1 (grant low, busy low). If another request is pending, its start is high in cycle n+2.
- done, abort and start are never asserted for more than one cycle. done and abort are never asserted together.

Test Plan:
1. Reset, then req[1] with tune=2 and vol=300 in cycle 0 → start=4'b0100 in cycle 2 only; grant=3'b010; volume_in=300. tran_end at cycle 20 → done[1] at 21; busy=0 at 21.
2. Beep playing (req[2], tune 1), then req[0] with tune 3 → abort[2] next cycle; start=4'b1000; grant=3'b001; beep not replayed.
3. Requester 0 repeating (REPEAT_MASK bit 0, GAP_CYC=4) → after tran_end, start re-pulses exactly 5 cycles later. cancel[0] during GAP → abort[0]; IDLE; no further start.
4. req[1] and req[2] in the same cycle → 1 plays first. tran_end → done[1], then start for 2 one cycle later.
5. TMO_CYC=16 with no tran_end → abort pulse 16 cycles after entering PLAY; FSM in IDLE.
6. mute toggled during PLAY → volume_in 0 next cycle and restored after release. Tune id 3 with MSC_N=3 → no start; abort. cancel and tran_end in the same cycle → abort only. Reset asserted mid-PLAY → all outputs 0 next cycle.

Source files
------------

// File: rtl/player_arb.sv
// player_arb: fixed-priority sequencer sharing one tune player between N_REQ requesters.
// Handles preemption, repeat-until-cancel with an inter-repeat gap, a watchdog and mute.
module player_arb #(
   parameter int unsigned      N_REQ       = 3,
   parameter int unsigned      MSC_N       = 4,
   parameter int unsigned      TW          = 2,
   parameter logic [N_REQ-1:0] REPEAT_MASK = 3'b001,
   parameter int unsigned      GAP_CYC     = 1000,
   parameter logic [31:0]      TMO_CYC     = 32'd50_000_000
) (
   input  logic                sysclk,
   input  logic                rst,
   input  logic [N_REQ-1:0]    req,
   input  logic [N_REQ-1:0]    cancel,
   input  logic [N_REQ*TW-1:0] req_tune,
   input  logic [N_REQ*10-1:0] req_vol,
   input  logic                mute,
   output logic [MSC_N-1:0]    start,
   output logic [9:0]          volume_in,
   input  logic                tran_end,
   output logic [N_REQ-1:0]    grant,
   output logic [N_REQ-1:0]    done,
   output logic [N_REQ-1:0]    abort,
   output logic                busy
);

   localparam int unsigned AW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_START, ST_PLAY, ST_GAP} state_t;

   state_t           state;
   logic [N_REQ-1:0] pending;
   logic [TW-1:0]    tune_q [N_REQ];
   logic [9:0]       vol_q  [N_REQ];
   logic [AW-1:0]    act;
   logic [TW-1:0]    act_tune;
   logic [9:0]       act_vol;
   logic [31:0]      cnt;

   logic             pick_vld;
   logic [AW-1:0]    pick_idx;
   logic             preempt;

   function automatic logic [MSC_N-1:0] onehot_tune(input logic [TW-1:0] t);
      onehot_tune = '0;
      for (int k = 0; k < MSC_N; k++)
         if (t == TW'(k)) onehot_tune[k] = 1'b1;
   endfunction

   function automatic logic tune_ok(input logic [TW-1:0] t);
      return 32'(t) < MSC_N;
   endfunction

   function automatic logic [N_REQ-1:0] onehot_req(input logic [AW-1:0] a);
      onehot_req    = '0;
      onehot_req[a] = 1'b1;
   endfunction

   // Lowest pending index wins; a pending index below act means preemption.
   always_comb begin
      pick_vld = |pending;
      pick_idx = '0;
      for (int i = N_REQ - 1; i >= 0; i--)
         if (pending[i]) pick_idx = AW'(i);
   end

   assign preempt = pick_vld && (pick_idx < act);
   assign busy    = (state != ST_IDLE);

   always_ff @(posedge sysclk) begin
      if (rst) begin
         state     <= ST_IDLE;
         pending   <= '0;
         act       <= '0;
         act_tune  <= '0;
         act_vol   <= '0;
         cnt       <= '0;
         start     <= '0;
         volume_in <= '0;
         grant     <= '0;
         done      <= '0;
         abort     <= '0;
         // NOTE: the tune/vol latches are cleared as well, so a stale id can never leak out after reset.
         for (int i = 0; i < N_REQ; i++) begin
            tune_q[i] <= '0;
            vol_q[i]  <= '0;
         end
      end else begin
         // NOTE: these defaults are overridden by later non-blocking assignments in the same pass.
         start     <= '0;
         done      <= '0;
         abort     <= '0;
         volume_in <= mute ? '0 : act_vol;

         unique case (state)
            ST_IDLE: begin
               if (pick_vld) begin
                  act               <= pick_idx;
                  act_tune          <= tune_q[pick_idx];
                  act_vol           <= vol_q[pick_idx];
                  pending[pick_idx] <= 1'b0;
                  start             <= onehot_tune(tune_q[pick_idx]);
                  grant             <= onehot_req(pick_idx);
                  volume_in         <= mute ? '0 : vol_q[pick_idx];
                  state             <= ST_START;
               end
            end

            ST_START: begin
               cnt <= '0;
               if (cancel[act] || !tune_ok(act_tune)) begin
                  abort <= onehot_req(act);
                  grant <= '0;
                  state <= ST_IDLE;
               end else begin
                  state <= ST_PLAY;
               end
            end

            ST_PLAY, ST_GAP: begin
               if (preempt) begin
                  abort             <= onehot_req(act);
                  act               <= pick_idx;
                  act_tune          <= tune_q[pick_idx];
                  act_vol           <= vol_q[pick_idx];
                  pending[pick_idx] <= 1'b0;
                  start             <= onehot_tune(tune_q[pick_idx]);
                  grant             <= onehot_req(pick_idx);
                  volume_in         <= mute ? '0 : vol_q[pick_idx];
                  state             <= ST_START;
               end else if (cancel[act]) begin
                  abort <= onehot_req(act);
                  grant <= '0;
                  state <= ST_IDLE;
               end else if (state == ST_GAP) begin
                  if (cnt == 32'(GAP_CYC - 1)) begin
                     start <= onehot_tune(act_tune);
                     cnt   <= '0;
                     state <= ST_START;
                  end else begin
                     cnt <= cnt + 32'd1;
                  end
               end else if (tran_end) begin
                  if (REPEAT_MASK[act]) begin
                     cnt   <= '0;
                     state <= ST_GAP;
                  end else begin
                     done  <= onehot_req(act);
                     grant <= '0;
                     state <= ST_IDLE;
                  end
               end else if (cnt == TMO_CYC - 32'd1) begin
                  abort <= onehot_req(act);
                  grant <= '0;
                  state <= ST_IDLE;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end

            default: state <= ST_IDLE;
         endcase

         // Requests and cancels land after any pick above, so a same-cycle re-request stays pending.
         for (int i = 0; i < N_REQ; i++) begin
            if (req[i]) begin
               tune_q[i] <= req_tune[i*TW +: TW];
               vol_q[i]  <= req_vol[i*10 +: 10];
            end
            if (cancel[i])   pending[i] <= 1'b0;
            else if (req[i]) pending[i] <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_player_arb.sv
// Bench for player_arb: directed scenarios with literal expectations, then random traffic
// compared every cycle against a behavioural session model.
module tb_player_arb;

   localparam int          N_REQ = 3;
   localparam int          MSC_N = 4;
   localparam int          TW    = 3;
   localparam int          GAP   = 4;
   localparam int          TMO   = 16;
   localparam logic [2:0]  RPT   = 3'b001;

   logic                sysclk   = 1'b0;
   logic                rst      = 1'b1;
   logic [N_REQ-1:0]    req      = '0;
   logic [N_REQ-1:0]    cancel   = '0;
   logic [N_REQ*TW-1:0] req_tune = '0;
   logic [N_REQ*10-1:0] req_vol  = '0;
   logic                mute     = 1'b0;
   logic                tran_end = 1'b0;
   logic [MSC_N-1:0]    start;
   logic [9:0]          volume_in;
   logic [N_REQ-1:0]    grant;
   logic [N_REQ-1:0]    done;
   logic [N_REQ-1:0]    abort;
   logic                busy;

   int tests = 0;
   int fails = 0;

   player_arb #(
      .N_REQ(N_REQ), .MSC_N(MSC_N), .TW(TW), .REPEAT_MASK(RPT),
      .GAP_CYC(GAP), .TMO_CYC(32'(TMO))
   ) dut (
      .sysclk(sysclk), .rst(rst), .req(req), .cancel(cancel),
      .req_tune(req_tune), .req_vol(req_vol), .mute(mute),
      .start(start), .volume_in(volume_in), .tran_end(tran_end),
      .grant(grant), .done(done), .abort(abort), .busy(busy)
   );

   always #5 sysclk = ~sysclk;

   // Session model: who owns the player, how long it has played, how much gap is left.
   bit               m_pend [N_REQ];
   int               m_tune [N_REQ];
   int               m_vol  [N_REQ];
   int               m_owner;
   int               m_cur_tune;
   int               m_cur_vol;
   int               m_play_age;
   int               m_gap_left;
   bit               m_fresh;
   logic [MSC_N-1:0] e_start;
   logic [N_REQ-1:0] e_grant, e_done, e_abort;
   logic [9:0]       e_vol;
   logic             e_busy;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [MSC_N-1:0] tune_bit(input int t);
      return (t < MSC_N) ? (MSC_N'(1) << t) : '0;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N_REQ; i++) begin
         m_pend[i] = 1'b0; m_tune[i] = 0; m_vol[i] = 0;
      end
      m_owner = -1; m_cur_tune = 0; m_cur_vol = 0;
      m_play_age = 0; m_gap_left = 0; m_fresh = 1'b0;
      e_start = '0; e_grant = '0; e_done = '0; e_abort = '0; e_vol = '0; e_busy = 1'b0;
   endtask

   task automatic m_launch(input int j);
      m_owner    = j;
      m_cur_tune = m_tune[j];
      m_cur_vol  = m_vol[j];
      e_start    = tune_bit(m_cur_tune);
      e_vol      = mute ? 10'd0 : 10'(m_cur_vol);
      m_fresh    = 1'b1;
      m_gap_left = 0;
      m_play_age = 0;
   endtask

   task automatic m_release();
      m_owner = -1; m_fresh = 1'b0; m_gap_left = 0;
   endtask

   // Consumes the inputs of the cycle just ended and predicts the outputs of the next one.
   task automatic model_step();
      int hp, taken;
      if (rst) begin
         model_reset();
         return;
      end
      e_start = '0; e_done = '0; e_abort = '0;
      e_vol   = mute ? 10'd0 : 10'(m_cur_vol);
      hp = -1;
      for (int i = N_REQ - 1; i >= 0; i--) if (m_pend[i]) hp = i;
      taken = -1;
      if (m_owner < 0) begin
         if (hp >= 0) begin m_launch(hp); taken = hp; end
      end else if (m_fresh) begin
         if (cancel[m_owner] || m_cur_tune >= MSC_N) begin
            e_abort[m_owner] = 1'b1; m_release();
         end else begin
            m_fresh = 1'b0; m_play_age = 0;
         end
      end else if (hp >= 0 && hp < m_owner) begin
         e_abort[m_owner] = 1'b1; m_launch(hp); taken = hp;
      end else if (cancel[m_owner]) begin
         e_abort[m_owner] = 1'b1; m_release();
      end else if (m_gap_left > 0) begin
         m_gap_left--;
         if (m_gap_left == 0) begin e_start = tune_bit(m_cur_tune); m_fresh = 1'b1; end
      end else if (tran_end) begin
         if (RPT[m_owner]) m_gap_left = GAP;
         else begin e_done[m_owner] = 1'b1; m_release(); end
      end else if (m_play_age == TMO - 1) begin
         e_abort[m_owner] = 1'b1; m_release();
      end else begin
         m_play_age++;
      end
      if (taken >= 0) m_pend[taken] = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (req[i]) begin
            m_tune[i] = int'(req_tune[i*TW +: TW]);
            m_vol[i]  = int'(req_vol[i*10 +: 10]);
         end
         if (cancel[i])   m_pend[i] = 1'b0;
         else if (req[i]) m_pend[i] = 1'b1;
      end
      e_grant = '0;
      if (m_owner >= 0) e_grant[m_owner] = 1'b1;
      e_busy = (m_owner >= 0);
   endtask

   task automatic tick();
      @(posedge sysclk);
      model_step();
      @(negedge sysclk);
      check("m_start", 32'(start),     32'(e_start));
      check("m_grant", 32'(grant),     32'(e_grant));
      check("m_done",  32'(done),      32'(e_done));
      check("m_abort", 32'(abort),     32'(e_abort));
      check("m_vol",   32'(volume_in), 32'(e_vol));
      check("m_busy",  32'(busy),      32'(e_busy));
   endtask

   task automatic step(input logic [N_REQ-1:0] r, input logic [N_REQ-1:0] c, input logic te);
      req = r; cancel = c; tran_end = te;
      tick();
      req = '0; cancel = '0; tran_end = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step('0, '0, 1'b0);
   endtask

   task automatic set_rq(input int i, input int t, input int v);
      req_tune[i*TW +: TW] = TW'(t);
      req_vol[i*10 +: 10]  = 10'(v);
   endtask

   initial begin
      logic [N_REQ-1:0] r, c;
      model_reset();

      // Reset state
      tick(); tick();
      rst = 1'b0;
      check("rst_start", 32'(start), 32'h0);
      check("rst_grant", 32'(grant), 32'h0);
      check("rst_busy",  32'(busy),  32'h0);
      check("rst_vol",   32'(volume_in), 32'h0);
      idle(2);

      // Basic play: start at cycle 2, done the cycle after tran_end
      set_rq(1, 2, 300);
      step(3'b010, '0, 1'b0);                        // now cycle 1
      check("t1_start_c1", 32'(start), 32'h0);
      idle(1);                                       // cycle 2
      check("t1_start_c2", 32'(start), 32'h4);
      check("t1_grant_c2", 32'(grant), 32'h2);
      check("t1_vol_c2",   32'(volume_in), 32'd300);
      idle(1);                                       // cycle 3
      check("t1_start_c3", 32'(start), 32'h0);
      check("t1_grant_c3", 32'(grant), 32'h2);
      idle(9);                                       // cycle 12
      step('0, '0, 1'b1);                            // cycle 13
      check("t1_done",  32'(done), 32'h2);
      check("t1_busy",  32'(busy), 32'h0);
      check("t1_grant", 32'(grant), 32'h0);
      idle(3);

      // Preemption of a beep by requester 0
      set_rq(2, 1, 100);
      step(3'b100, '0, 1'b0); idle(1);               // cycle 2
      check("t2_beep_start", 32'(start), 32'h2);
      idle(1);                                       // cycle 3
      set_rq(0, 3, 500);
      step(3'b001, '0, 1'b0); idle(1);               // cycle 5
      check("t2_abort", 32'(abort), 32'h4);
      check("t2_start", 32'(start), 32'h8);
      check("t2_grant", 32'(grant), 32'h1);
      check("t2_vol",   32'(volume_in), 32'd500);
      idle(1);                                       // cycle 6
      step('0, 3'b001, 1'b0);                        // cycle 7
      check("t2_cancel_abort", 32'(abort), 32'h1);
      idle(4);
      check("t2_no_replay", 32'(busy), 32'h0);

      // Repeat with gap, then cancel during the gap
      set_rq(0, 2, 200);
      step(3'b001, '0, 1'b0); idle(2);               // cycle 3 (play)
      step('0, '0, 1'b1);                            // cycle 4 (gap)
      check("t3_gap_grant", 32'(grant), 32'h1);
      check("t3_gap_done",  32'(done),  32'h0);
      idle(3);                                       // cycle 7
      check("t3_no_early", 32'(start), 32'h0);
      idle(1);                                       // cycle 8
      check("t3_repulse", 32'(start), 32'h4);
      idle(1);                                       // cycle 9
      step('0, '0, 1'b1);                            // cycle 10 (gap)
      step('0, 3'b001, 1'b0);                        // cycle 11
      check("t3_abort", 32'(abort), 32'h1);
      check("t3_busy",  32'(busy),  32'h0);
      idle(8);

      // Simultaneous requests: 1 before 2
      set_rq(1, 1, 10); set_rq(2, 3, 20);
      step(3'b110, '0, 1'b0); idle(1);               // cycle 2
      check("t4_first", 32'(start), 32'h2);
      check("t4_grant", 32'(grant), 32'h2);
      idle(1);
      step('0, '0, 1'b1);                            // cycle 4
      check("t4_done1", 32'(done), 32'h2);
      idle(1);                                       // cycle 5
      check("t4_second", 32'(start), 32'h8);
      check("t4_grant2", 32'(grant), 32'h4);
      idle(1);
      step('0, '0, 1'b1);
      check("t4_done2", 32'(done), 32'h4);
      idle(2);

      // Watchdog
      set_rq(1, 0, 50);
      step(3'b010, '0, 1'b0); idle(2);               // cycle 3, first PLAY cycle
      idle(15);                                      // cycle 18
      check("t5_pre_abort", 32'(abort), 32'h0);
      check("t5_pre_busy",  32'(busy),  32'h1);
      idle(1);                                       // cycle 19
      check("t5_abort", 32'(abort), 32'h2);
      check("t5_idle",  32'(busy),  32'h0);
      idle(2);

      // Mute during play
      set_rq(1, 1, 700);
      step(3'b010, '0, 1'b0); idle(2);               // cycle 3
      mute = 1'b1;
      idle(1);                                       // cycle 4
      check("t6_muted", 32'(volume_in), 32'h0);
      idle(1);
      mute = 1'b0;
      idle(1);                                       // cycle 6
      check("t6_unmuted", 32'(volume_in), 32'd700);
      step('0, '0, 1'b1);
      check("t6_done", 32'(done), 32'h2);
      idle(2);

      // Out-of-range tune id
      set_rq(2, 5, 100);
      step(3'b100, '0, 1'b0); idle(1);               // cycle 2
      check("t6_bad_start", 32'(start), 32'h0);
      check("t6_bad_grant", 32'(grant), 32'h4);
      idle(1);
      check("t6_bad_abort", 32'(abort), 32'h4);
      check("t6_bad_busy",  32'(busy),  32'h0);
      idle(2);

      // Cancel and tran_end together
      set_rq(2, 0, 100);
      step(3'b100, '0, 1'b0); idle(2);
      step('0, 3'b100, 1'b1);
      check("t6_ct_abort", 32'(abort), 32'h4);
      check("t6_ct_done",  32'(done),  32'h0);
      idle(2);

      // Req and cancel in the same cycle: cancel wins
      set_rq(1, 1, 1);
      step(3'b010, 3'b010, 1'b0); idle(3);
      check("t6_rc_busy", 32'(busy), 32'h0);

      // Reset mid-play
      set_rq(1, 2, 300);
      step(3'b010, '0, 1'b0); idle(2);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      check("t6_rst_start", 32'(start), 32'h0);
      check("t6_rst_grant", 32'(grant), 32'h0);
      check("t6_rst_busy",  32'(busy),  32'h0);
      check("t6_rst_vol",   32'(volume_in), 32'h0);
      check("t6_rst_evts",  32'({done, abort}), 32'h0);
      idle(3);

      // Random traffic against the model
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < N_REQ; i++) begin
            r[i] = ($urandom_range(0, 11) == 0);
            c[i] = ($urandom_range(0, 39) == 0);
            set_rq(i, ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, 7))
                                                   : int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 1023)));
         end
         if ($urandom_range(0, 49) == 0) mute = ~mute;
         rst = ($urandom_range(0, 499) == 0);
         step(r, c, ($urandom_range(0, 5) == 0));
         rst = 1'b0;
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
